// File: rtl/raster_frame_writer.sv
// Raster pixel stream -> framebuffer (x, y) writes with geometry checking.
// Optional saturating error counter: define RASTER_WR_ERRCOUNT_EN.
module raster_frame_writer #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int N        = 9
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sof,
  input  logic         in_eol,
  input  logic [7:0]   in_data,
  output logic         wr_en,
  input  logic         wr_ready,
  output logic [N-1:0] wr_x,
  output logic [N-1:0] wr_y,
  output logic [7:0]   wr_data,
  output logic         frame_done,
  output logic         line_err,
  output logic         frame_err,
  output logic [7:0]   err_count
);

  localparam logic [N-1:0] XMAX = N'(H_PIXELS - 1);
  localparam logic [N-1:0] YMAX = N'(V_LINES - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t       state_q;
  logic [N-1:0] x_q, y_q;
  logic         wr_en_q;
  logic [N-1:0] wr_x_q, wr_y_q;
  logic [7:0]   wr_data_q;
  logic         frame_done_q, line_err_q, frame_err_q;

  logic acc, take, at_xmax, wrap, le_d, fe_d;

  assign in_ready = ~wr_en_q | wr_ready;
  assign acc      = in_valid & in_ready & ~clear;
  // A beat produces a write when it starts a frame or lands inside one.
  assign take     = acc & (in_sof | (state_q == ACTIVE));
  assign at_xmax  = (x_q == XMAX);
  assign wrap     = in_eol | at_xmax;
  assign fe_d     = take & in_sof & (state_q == ACTIVE);
  assign le_d     = take & ~in_sof & (in_eol ? ~at_xmax : at_xmax);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      wr_en_q      <= 1'b0;
      wr_x_q       <= '0;
      wr_y_q       <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      line_err_q   <= le_d;
      frame_err_q  <= fe_d;
      if (clear) begin
        state_q <= IDLE;
        x_q     <= '0;
        y_q     <= '0;
        wr_en_q <= 1'b0;
      end else if (take) begin
        wr_en_q   <= 1'b1;
        wr_data_q <= in_data;
        state_q   <= ACTIVE;
        if (in_sof) begin
          wr_x_q <= '0;
          wr_y_q <= '0;
          if (in_eol) begin
            x_q <= '0;
            y_q <= N'(1);
          end else begin
            x_q <= N'(1);
            y_q <= '0;
          end
        end else begin
          wr_x_q <= x_q;
          wr_y_q <= y_q;
          if (wrap) begin
            x_q <= '0;
            if (y_q == YMAX) begin
              frame_done_q <= 1'b1;
              y_q          <= '0;
              state_q      <= IDLE;
            end else begin
              y_q <= y_q + N'(1);
            end
          end else begin
            x_q <= x_q + N'(1);
          end
        end
      end else if (wr_ready) begin
        wr_en_q <= 1'b0;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;

`ifdef RASTER_WR_ERRCOUNT_EN
  logic [7:0] err_count_q;

  // Counts a beat once even if it raises both error pulses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_count_q <= '0;
    end else if (clear) begin
      err_count_q <= '0;
    end else if ((le_d | fe_d) && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: doc/raster_frame_writer.md
# raster_frame_writer

Receiving end of the raster scan path: accepts an 8-bit pixel stream framed with start-of-frame and end-of-line markers and converts it back into (x, y) framebuffer write addresses. It mirrors the horizontal/vertical scan counters and checks each incoming frame against the configured geometry. It sits between the pixel source and the framebuffer write port, with a one-entry output register and back-pressure in both directions.

## Interface
- H_PIXELS, 320, pixels per line; x runs 0..H_PIXELS-1
- V_LINES, 240, lines per frame; y runs 0..V_LINES-1
- N, 9, width of the x and y coordinate outputs
- clk  in  1  clock; all state updates on the rising edge
- nrst  in  1  asynchronous active-low reset
- clear  in  1  synchronous active-high clear
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat
- in_sof  in  1  beat is the first pixel of a frame
- in_eol  in  1  beat is the last pixel of a line
- in_data  in  8  pixel value
- wr_en  out  1  framebuffer write pending
- wr_ready  in  1  framebuffer takes the write this cycle
- wr_x  out  N  write column
- wr_y  out  N  write row
- wr_data  out  8  write pixel
- frame_done  out  1  one-cycle pulse: last pixel of a frame accepted
- line_err  out  1  one-cycle pulse: line length differed from H_PIXELS
- frame_err  out  1  one-cycle pulse: SOF arrived mid-frame
- err_count  out  8  saturating error count (see Configuration)

## Operation
- Beat accepted when in_valid && in_ready. in_ready = ~wr_en | wr_ready (combinational).
- States: IDLE (waiting for SOF), ACTIVE. x_cnt and y_cnt track the next write position.
- IDLE, accepted beat with in_sof=1: write at (0,0). x_cnt becomes 1, or 0 with y_cnt 1 if in_eol. Go to ACTIVE.
- IDLE, accepted beat with in_sof=0: discarded, with no write and no error.
- ACTIVE, accepted beat with in_sof=1: frame_err pulses, and the beat is handled exactly as the SOF beat in IDLE.
- ACTIVE, accepted beat with in_eol=1:
  - Write at (x_cnt, y_cnt).
  - If x_cnt != H_PIXELS-1, line_err pulses.
  - Then x_cnt becomes 0. If y_cnt == V_LINES-1, frame_done pulses, y_cnt becomes 0 and the state returns to IDLE; otherwise y_cnt increments.
- ACTIVE, accepted beat with in_eol=0 and x_cnt == H_PIXELS-1: write, line_err pulses, and the line wraps exactly as if in_eol were set (including frame_done on the last line).
- Otherwise: write at (x_cnt, y_cnt), then x_cnt increments.
- A beat carrying both in_sof and in_eol is legal; its SOF handling comes first.
- clear has priority over all activity. On clear:
  - state returns to IDLE and x_cnt/y_cnt to 0;
  - wr_en drops and any pending write is lost;
  - pulses are suppressed and err_count is zeroed.

## Timing
- Reset values: wr_en=0, wr_x=0, wr_y=0, wr_data=0, frame_done=0, line_err=0, frame_err=0, err_count=0, state IDLE. in_ready=1 while reset is asserted and after release.
- Latency: a beat accepted at edge k appears on wr_en/wr_x/wr_y/wr_data after edge k. The frame_done, line_err and frame_err pulses for that beat are high during the same cycle.
- Pulses last exactly one cycle, even if wr_en stays stalled.
- Output registers hold while wr_en && ~wr_ready.
- Full throughput: with wr_ready held at 1, one beat is accepted every cycle.
- A write retires and a new beat is accepted in the same cycle whenever wr_ready=1.
- Coordinate arithmetic is N bits. x_cnt never exceeds H_PIXELS-1 and y_cnt never exceeds V_LINES-1.
- nrst asserted mid-frame forces every reset value immediately, regardless of clk.

## Configuration
- RASTER_WR_ERRCOUNT_EN defined:
  - err_count increments by 1 in each cycle where line_err or frame_err is high;
  - a single beat raising both pulses counts once;
  - the count saturates at 255 and is zeroed by clear or nrst.
- Not defined: err_count is tied to 0 and no counter logic exists.

## Test plan
All scenarios use H_PIXELS=4, V_LINES=3.
- Clean frame, wr_ready=1: 12 beats with SOF on beat 0 and EOL on beats 3, 7, 11 -> writes at (0,0)..(3,2) in order, frame_done only with (3,2), no errors, state IDLE afterwards.
- Pre-SOF garbage: 3 beats with in_sof=0, then a clean frame -> no writes for the 3 beats, and the frame is written exactly as in the clean-frame case.
- Short and long lines:
  - EOL on the 3rd beat of line 0 -> line_err with write (2,0), next write at (0,1).
  - Line 1 with no EOL on its 4th beat -> line_err with (3,1), next write at (0,2).
- Mid-frame SOF: SOF at (1,1) -> frame_err pulses and that beat is written at (0,0); with the macro defined, err_count=1.
- Back-pressure: wr_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 from the second beat onward, and wr_x/wr_y/wr_data are held. On release, no beat is lost or duplicated.
- clear and nrst mid-frame:
  - clear during line 1 with wr_en=1 -> next cycle wr_en=0, and the following non-SOF beats are discarded.
  - nrst asserted -> all outputs zero immediately.
